adder_result_collector: RTL and testbench

Downstream stage of the serial adder. It watches the adder's `en_o` start pulse and the serial `out` stream, and deserializes each 3-bit sum (MSB first) into a parallel word. Completed words are buffered in a small FIFO and offered to the consumer over a valid/ready handshake. The block also keeps sticky overflow and protocol-error flags and a running result count.

---
 rtl/adder_result_collector_pkg.sv | 16 +
 rtl/adder_result_collector_if.sv | 42 ++++
 rtl/adder_result_collector_fifo.sv | 54 +++++
 rtl/adder_result_collector.sv | 96 +++++++++
 tb/tb_adder_result_collector.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/adder_result_collector_pkg.sv
// Shared types for the serial-adder result collector: result width, collector
// FSM states and the parallel result word type.
package adder_pkg;

    localparam int unsigned RES_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        B2,
        B1,
        B0
    } coll_state_t;

    typedef logic [RES_W-1:0] res_t;

endpackage

// File: rtl/adder_result_collector_if.sv
// Bundle of the collector's adder-facing, consumer-facing and status signals.
// The collector takes the slave view; the adder/consumer side takes the master view.
interface adder_result_collector_if #(
    parameter int unsigned CNT_W = 8
);
    import adder_pkg::*;

    logic             en_o;
    logic             out;
    res_t             res_data;
    logic             res_valid;
    logic             res_ready;
    logic             overflow;
    logic             proto_err;
    logic             clr_flags;
    logic [CNT_W-1:0] res_count;

    modport master (
        output en_o,
        output out,
        output res_ready,
        output clr_flags,
        input  res_data,
        input  res_valid,
        input  overflow,
        input  proto_err,
        input  res_count
    );

    modport slave (
        input  en_o,
        input  out,
        input  res_ready,
        input  clr_flags,
        output res_data,
        output res_valid,
        output overflow,
        output proto_err,
        output res_count
    );

endinterface

// File: rtl/adder_result_collector_fifo.sv
// Show-ahead FIFO for completed result words. Pointers carry one extra wrap bit
// so full and empty fall out of a plain pointer compare.
module adder_res_fifo
    import adder_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         data_t = res_t
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  data_t push_data,
    input  logic  pop,
    output data_t rd_data,
    output logic  full,
    output logic  empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    data_t       mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && !empty;
        // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        rd_data  = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_data;
            end
        end
    end

endmodule

// File: rtl/adder_result_collector.sv
// Deserializes each 3-bit serial sum (MSB first) after an en_o pulse, buffers the
// words in a FIFO and tracks sticky overflow / protocol-error flags and a push count.
module adder_result_collector
    import adder_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    adder_result_collector_if.slave  bus
);

    coll_state_t      state_q, state_d;
    logic [RES_W-1:1] sh_q, sh_d;
    logic             overflow_q, overflow_d;
    logic             proto_err_q, proto_err_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             push;
    res_t             push_word;
    logic             pop;
    logic             accept;
    logic             fifo_full;
    logic             fifo_empty;
    res_t             fifo_rd_data;

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        push      = 1'b0;
        push_word = {sh_q, bus.out};
        unique case (state_q)
            IDLE: begin
                if (bus.en_o) begin
                    state_d = B2;
                end
            end
            B2, B1: begin
                sh_d    = {sh_q[RES_W-2:1], bus.out};
                state_d = (state_q == B2) ? B1 : B0;
            end
            B0: begin
                push    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop    = !fifo_empty && bus.res_ready;
        accept = push && (!fifo_full || pop);
        // Set events take priority over a simultaneous clear.
        overflow_d  = (push && !accept) || (overflow_q && !bus.clr_flags);
        proto_err_d = (bus.en_o && (state_q != IDLE)) || (proto_err_q && !bus.clr_flags);
        count_d     = count_q + {{(CNT_W-1){1'b0}}, accept};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            overflow_q  <= overflow_d;
            proto_err_q <= proto_err_d;
            count_q     <= count_d;
        end
    end

    adder_res_fifo #(
        .DEPTH  (DEPTH),
        .data_t (res_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data (push_word),
        .pop       (pop),
        .rd_data   (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.res_data  = fifo_rd_data;
    assign bus.res_valid = !fifo_empty;
    assign bus.overflow  = overflow_q;
    assign bus.proto_err = proto_err_q;
    assign bus.res_count = count_q;

endmodule

// File: tb/tb_adder_result_collector.sv
// Directed bench for adder_result_collector: a vector table for single words plus
// hand-written sequences for back-to-back, overflow, push-with-pop, protocol and reset cases.
module tb_adder_result_collector;

    logic clk;
    logic rst_n;

    adder_result_collector_if #(.CNT_W(8)) bus ();

    adder_result_collector #(
        .DEPTH (4),
        .CNT_W (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] word;
        logic [2:0] exp_data;
        int         exp_count;
    } vec_t;

    vec_t       vecs [6];
    logic [2:0] rxq [$];
    logic [2:0] exp5 [5];
    int         checks;
    int         errors;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Log handshakes just before the edge, then move to 1 time unit after it.
    task automatic tick();
        @(negedge clk);
        if (bus.res_valid && bus.res_ready) rxq.push_back(bus.res_data);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.en_o      = 1'b0;
        bus.out       = 1'b0;
        bus.res_ready = 1'b0;
        bus.clr_flags = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send_word(input logic [2:0] w, input logic rdy_last);
        bus.en_o = 1'b1;
        tick();
        bus.en_o = 1'b0;
        bus.out  = w[2];
        tick();
        bus.out  = w[1];
        tick();
        bus.out  = w[0];
        if (rdy_last) bus.res_ready = 1'b1;
        tick();
        bus.out = 1'b0;
        if (rdy_last) bus.res_ready = 1'b0;
    endtask

    task automatic chk_rx(input string nm, input int n);
        chk({nm, "_size"}, rxq.size(), n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_%0d", nm, i), (i < rxq.size()) ? {29'd0, rxq[i]} : 32'hx,
                {29'd0, exp5[i]});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vecs[0] = '{word: 3'b000, exp_data: 3'b000, exp_count: 1};
        vecs[1] = '{word: 3'b111, exp_data: 3'b111, exp_count: 2};
        vecs[2] = '{word: 3'b010, exp_data: 3'b010, exp_count: 3};
        vecs[3] = '{word: 3'b100, exp_data: 3'b100, exp_count: 4};
        vecs[4] = '{word: 3'b001, exp_data: 3'b001, exp_count: 5};
        vecs[5] = '{word: 3'b110, exp_data: 3'b110, exp_count: 6};

        rst_n         = 1'b0;
        bus.en_o      = 1'b0;
        bus.out       = 1'b0;
        bus.res_ready = 1'b0;
        bus.clr_flags = 1'b0;
        #1;
        chk("rst_valid", bus.res_valid, 0);
        chk("rst_data", bus.res_data, 0);
        chk("rst_count", bus.res_count, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_perr", bus.proto_err, 0);

        // Basic word 101 with latency check.
        do_reset();
        bus.en_o = 1'b1; tick();
        bus.en_o = 1'b0; bus.out = 1'b1; tick();
        bus.out = 1'b0; tick();
        bus.out = 1'b1;
        chk("lat_valid_t3", bus.res_valid, 0);
        tick();
        bus.out = 1'b0;
        chk("basic_valid", bus.res_valid, 1);
        chk("basic_data", bus.res_data, 3'b101);
        chk("basic_count", bus.res_count, 1);
        tick();
        chk("basic_hold_data", bus.res_data, 3'b101);

        // Vector table: one word at a time, then a single pop.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send_word(vecs[i].word, 1'b0);
            chk($sformatf("vec%0d_valid", i), bus.res_valid, 1);
            chk($sformatf("vec%0d_data", i), bus.res_data, vecs[i].exp_data);
            chk($sformatf("vec%0d_count", i), bus.res_count, vecs[i].exp_count);
            bus.res_ready = 1'b1;
            tick();
            bus.res_ready = 1'b0;
            chk($sformatf("vec%0d_popped", i), bus.res_valid, 0);
        end

        // Four back-to-back words, consumer always ready.
        do_reset();
        rxq.delete();
        exp5 = '{3'b111, 3'b000, 3'b110, 3'b011, 3'b000};
        bus.res_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_word(exp5[i], 1'b0);
        repeat (2) tick();
        bus.res_ready = 1'b0;
        chk_rx("b2b", 4);
        chk("b2b_ovf", bus.overflow, 0);
        chk("b2b_count", bus.res_count, 4);
        chk("b2b_empty", bus.res_valid, 0);

        // Five words into a depth-4 FIFO with no consumer.
        do_reset();
        rxq.delete();
        exp5 = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
        for (int i = 0; i < 4; i++) send_word(exp5[i], 1'b0);
        chk("ovf_before", bus.overflow, 0);
        send_word(exp5[4], 1'b0);
        chk("ovf_set", bus.overflow, 1);
        chk("ovf_count", bus.res_count, 4);
        chk("ovf_head", bus.res_data, 3'b001);
        bus.res_ready = 1'b1;
        repeat (6) tick();
        bus.res_ready = 1'b0;
        chk_rx("ovf_drain", 4);
        chk("ovf_sticky", bus.overflow, 1);

        // Full FIFO: fifth push coincides with a pop and is accepted.
        do_reset();
        rxq.delete();
        exp5 = '{3'b110, 3'b101, 3'b011, 3'b111, 3'b010};
        for (int i = 0; i < 4; i++) send_word(exp5[i], 1'b0);
        send_word(exp5[4], 1'b1);
        chk("pp_ovf", bus.overflow, 0);
        chk("pp_count", bus.res_count, 5);
        chk("pp_head", bus.res_data, 3'b101);
        bus.res_ready = 1'b1;
        repeat (6) tick();
        bus.res_ready = 1'b0;
        chk_rx("pp_drain", 5);

        // en_o reasserted mid-word: flagged, ignored, word completes.
        do_reset();
        bus.en_o = 1'b1; tick();
        bus.en_o = 1'b0; bus.out = 1'b1; tick();
        chk("perr_clean", bus.proto_err, 0);
        bus.en_o = 1'b1; bus.out = 1'b0; tick();
        bus.en_o = 1'b0; bus.out = 1'b1;
        chk("perr_set", bus.proto_err, 1);
        tick();
        bus.out = 1'b0;
        chk("perr_valid", bus.res_valid, 1);
        chk("perr_data", bus.res_data, 3'b101);
        repeat (5) tick();
        chk("perr_no_restart", bus.res_count, 1);
        bus.clr_flags = 1'b1; tick();
        bus.clr_flags = 1'b0;
        chk("perr_cleared", bus.proto_err, 0);

        // Clear coinciding with a set event: set wins.
        bus.en_o = 1'b1; tick();
        bus.en_o = 1'b1; bus.clr_flags = 1'b1; tick();
        bus.en_o = 1'b0; bus.clr_flags = 1'b0;
        chk("perr_set_wins", bus.proto_err, 1);
        repeat (3) tick();

        // Asynchronous reset in the middle of a word.
        do_reset();
        send_word(3'b110, 1'b0);
        bus.en_o = 1'b1; tick();
        bus.out = 1'b1; tick();
        bus.en_o = 1'b0;
        chk("mid_pre_perr", bus.proto_err, 1);
        chk("mid_pre_valid", bus.res_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.res_valid, 0);
        chk("mid_rst_data", bus.res_data, 0);
        chk("mid_rst_count", bus.res_count, 0);
        chk("mid_rst_perr", bus.proto_err, 0);
        chk("mid_rst_ovf", bus.overflow, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out = 1'b1;
        repeat (6) tick();
        bus.out = 1'b0;
        chk("mid_no_stale", bus.res_valid, 0);
        chk("mid_no_count", bus.res_count, 0);
        send_word(3'b011, 1'b0);
        chk("mid_next_valid", bus.res_valid, 1);
        chk("mid_next_data", bus.res_data, 3'b011);
        chk("mid_next_count", bus.res_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
